// File: rtl/pr_read_sequencer.sv
// pr_read_sequencer: splits an element range into line reads and drains each line from the read buffer.
// Ports: clk/rst_n (sync, active-low); req_* range request handshake; mem_rd_* line read request;
//        mem_rsp_valid line arrival; buf_* read-buffer control; out_* element stream with last;
//        done completion pulse; busy while not idle.
// Optional: define PR_SEQ_STATS_EN to add stat_lines / stat_stall saturating counters.
module pr_read_sequencer #(
    parameter int FULL_WIDTH = 512,
    parameter int WIDTH      = 64,
    parameter int IDX_W      = 32,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W-1:0]  req_start,
    input  logic [IDX_W-1:0]  req_end,
    output logic              mem_rd_valid,
    input  logic              mem_rd_ready,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rsp_valid,
    output logic              buf_load,
    output logic [7:0]        buf_base,
    output logic [7:0]        buf_bounds,
    input  logic              buf_oready,
    output logic              buf_pop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done,
    output logic              busy
`ifdef PR_SEQ_STATS_EN
    ,
    output logic [31:0]       stat_lines,
    output logic [31:0]       stat_stall
`endif
);
    localparam int ELEMS = FULL_WIDTH / WIDTH;
    localparam int LOG   = $clog2(ELEMS);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, LOAD, DRAIN} state_t;

    state_t           state;
    logic [IDX_W-1:0] cur_idx, end_idx, line_cnt, rem;
    logic             last_line;
    logic [IDX_W-1:0] off, avail, left, cnt;

    // Elements of the current line: limited by both the line end and the request end.
    always_comb begin
        off   = cur_idx & IDX_W'(ELEMS - 1);
        avail = IDX_W'(ELEMS) - off;
        left  = end_idx - cur_idx;
        cnt   = left < avail ? left : avail;
    end

    assign req_ready    = state == IDLE;
    assign busy         = state != IDLE;
    assign mem_rd_valid = state == ISSUE;
    assign mem_rd_addr  = ADDR_W'(cur_idx >> LOG);
    assign buf_load     = state == WAIT_RSP && mem_rsp_valid;
    assign out_valid    = state == DRAIN && buf_oready;
    assign buf_pop      = out_valid && out_ready;
    assign out_last     = out_valid && rem == IDX_W'(1) && last_line;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_idx    <= '0;
            end_idx    <= '0;
            line_cnt   <= '0;
            rem        <= '0;
            last_line  <= 1'b0;
            buf_base   <= '0;
            buf_bounds <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    cur_idx <= req_start;
                    end_idx <= req_end;
                    if (req_end <= req_start) done <= 1'b1;
                    else state <= ISSUE;
                end
                ISSUE: if (mem_rd_ready) begin
                    state      <= WAIT_RSP;
                    buf_base   <= off[7:0];
                    buf_bounds <= off[7:0] + cnt[7:0];
                    line_cnt   <= cnt;
                    rem        <= cnt;
                    last_line  <= cur_idx + cnt == end_idx;
                end
                WAIT_RSP: if (mem_rsp_valid) state <= LOAD;
                // Buffer registers its element count this cycle; popping waits for DRAIN.
                LOAD: state <= DRAIN;
                DRAIN: if (buf_pop) begin
                    rem <= rem - IDX_W'(1);
                    if (rem == IDX_W'(1)) begin
                        cur_idx <= cur_idx + line_cnt;
                        state   <= last_line ? IDLE : ISSUE;
                        done    <= last_line;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PR_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_lines <= '0;
            stat_stall <= '0;
        end else begin
            if (mem_rd_valid && mem_rd_ready && stat_lines != '1) stat_lines <= stat_lines + 32'd1;
            if (out_valid && !out_ready && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

    // A new line must never land on a buffer that still holds elements.
    rsp_into_full_buffer: assert property (@(posedge clk) disable iff (!rst_n)
        !(state == WAIT_RSP && mem_rsp_valid && buf_oready));
endmodule

// File: tb/tb_pr_read_sequencer.sv
// tb_pr_read_sequencer: directed vector bench with a line-buffer model for pr_read_sequencer.
module tb_pr_read_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_start = '0, req_end = '0;
    logic        mem_rd_valid, mem_rd_ready = 1'b0;
    logic [31:0] mem_rd_addr;
    logic        mem_rsp_valid = 1'b0, buf_load;
    logic [7:0]  buf_base, buf_bounds;
    logic        buf_oready, buf_pop, out_valid, out_ready = 1'b0, out_last, done, busy;
    logic [7:0]  bcnt;

    pr_read_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_start(req_start), .req_end(req_end), .mem_rd_valid(mem_rd_valid),
        .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr), .mem_rsp_valid(mem_rsp_valid),
        .buf_load(buf_load), .buf_base(buf_base), .buf_bounds(buf_bounds),
        .buf_oready(buf_oready), .buf_pop(buf_pop), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Line buffer model: loads bounds-base elements, pops one per buf_pop.
    assign buf_oready = bcnt != 8'd0;
    always @(posedge clk) begin
        if (!rst_n) bcnt <= 8'd0;
        else if (buf_load) bcnt <= buf_bounds - buf_base;
        else if (buf_pop) bcnt <= bcnt - 8'd1;
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int s, e;
        bit bp;
        int stall, rdly, abort, lines, elems;
    } vec_t;

    vec_t v[10];

    task automatic run(input vec_t t);
        int  cyc = 0, nread = 0, nload = 0, npop = 0, vcyc = 0, iss = 0, w = 0;
        int  lp = -1, rcyc = -100, mcur = t.s, lrem = 0, lcnt = 0, mb = 0;
        bit  pend = 0, first = 0, fin = 0, stall_prev = 0;
        logic last_prev = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1);
        req_valid = 1'b1; req_start = t.s; req_end = t.e;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0;
            mem_rsp_valid = 1'b0;
            if (pend) begin
                if (w == 0) begin mem_rsp_valid = 1'b1; pend = 0; rcyc = cyc; first = 1; end
                else w--;
            end
            mem_rd_ready = iss >= t.stall;
            out_ready = t.bp ? (cyc % 3 == 0) : 1'b1;
            #1;
            if (t.abort > 0 && npop == t.abort) begin
                rst_n = 1'b0;
                fin = 1;
            end else begin
                if (mem_rd_valid) begin
                    chk("rd_addr", mem_rd_addr, mcur >> 3);
                    vcyc++;
                    if (mem_rd_ready) begin nread++; pend = 1; w = t.rdly; iss = 0; end
                    else iss++;
                end
                chk("buf_load", buf_load, mem_rsp_valid);
                if (buf_load) begin
                    nload++;
                    mb = mcur % 8;
                    lcnt = (t.e - mcur) < (8 - mb) ? (t.e - mcur) : (8 - mb);
                    lrem = lcnt;
                    chk("buf_base", buf_base, mb);
                    chk("buf_bounds", buf_bounds, mb + lcnt);
                end
                if (first && out_valid) begin chk("rsp_to_valid", cyc - rcyc, 2); first = 0; end
                if (stall_prev) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_last", out_last, last_prev);
                end
                stall_prev = out_valid && !out_ready;
                last_prev = out_last;
                if (out_valid) begin
                    chk("buf_pop", buf_pop, out_ready);
                    chk("out_last", out_last, npop + 1 == t.elems);
                    if (out_ready) begin
                        npop++; lrem--; lp = cyc;
                        if (lrem == 0) mcur += lcnt;
                    end
                end
                if (done) begin
                    chk("done_time", cyc, t.elems == 0 ? 1 : lp + 1);
                    chk("done_req_ready", req_ready, 1);
                    chk("done_busy", busy, 0);
                    fin = 1;
                end else begin
                    chk("busy", busy, t.elems != 0);
                    chk("req_ready", req_ready, t.elems == 0);
                end
            end
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL timeout: got no done within %0d cycles want done for %0d..%0d", cyc, t.s, t.e);
        end
        mem_rsp_valid = 1'b0;
        if (t.abort > 0) begin
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk("abort_req_ready", req_ready, 1);
            chk("abort_busy", busy, 0);
            chk("abort_out_valid", out_valid, 0);
            chk("abort_rd_valid", mem_rd_valid, 0);
            chk("abort_done", done, 0);
        end else begin
            chk("reads", nread, t.lines);
            chk("loads", nload, t.lines);
            chk("elems", npop, t.elems);
            chk("rd_valid_cycles", vcyc, t.lines * (t.stall + 1));
        end
    endtask

    initial begin
        //        s   e  bp stall rdly abort lines elems
        v[0] = '{ 0,  8, 0, 0, 0, 0, 1,  8};
        v[1] = '{ 5, 19, 0, 0, 0, 0, 3, 14};
        v[2] = '{10, 10, 0, 0, 0, 0, 0,  0};
        v[3] = '{ 0,  4, 1, 0, 0, 0, 1,  4};
        v[4] = '{ 0,  8, 0, 5, 3, 0, 1,  8};
        v[5] = '{ 0,  8, 0, 0, 0, 2, 1,  8};
        v[6] = '{16, 17, 0, 0, 0, 0, 1,  1};
        v[7] = '{ 6, 30, 1, 0, 0, 0, 4, 24};
        v[8] = '{20, 10, 0, 0, 0, 0, 0,  0};
        v[9] = '{ 8, 16, 0, 0, 1, 0, 1,  8};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rd_valid", mem_rd_valid, 0);
        chk("rst_rd_addr", mem_rd_addr, 0);
        chk("rst_buf_load", buf_load, 0);
        chk("rst_buf_base", buf_base, 0);
        chk("rst_buf_bounds", buf_bounds, 0);
        chk("rst_buf_pop", buf_pop, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        for (int i = 0; i < 10; i++) run(v[i]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
